uart_term_rx: RTL
=================

UART_TERM_RX -- requirements
Module: uart_term_rx

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 234, clk cycles per UART bit (27 MHz / 115200); legal range 16..4095.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line from SoC UART TX, idle high.
REQ-006 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-007 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts head byte.
REQ-009 SHALL have port frame_err  output  1  sticky, stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky, byte lost to full FIFO.
REQ-011 SHALL have port par_err  output  1  sticky parity error; constant 0 when parity not compiled in.
REQ-012 SHALL have port err_clr  input  1  clears all sticky flags.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE: on rxd_s==0 go to START, bit counter loaded with BAUD_DIV/2-1 (integer division).
REQ-017 START: on counter==0 sample rxd_s; 1 -> IDLE (glitch rejected, no flag); 0 -> DATA, counter=BAUD_DIV-1, bit index=0.
REQ-018 DATA: on counter==0 sample rxd_s into bit[index], LSB first; after index 7 go to STOP (or PARITY); otherwise reload BAUD_DIV-1.
REQ-019 STOP: on counter==0 sample rxd_s; 1 -> push byte; 0 -> discard byte, set frame_err; in both cases return to IDLE in the next cycle, so a start bit immediately following is accepted.
REQ-020 Push to non-full FIFO SHALL make rx_valid high on the cycle after the stop sample, with no bubble.
REQ-021 Pop SHALL occur on every cycle where rx_valid && rx_ready; rx_data SHALL be stable while rx_valid && !rx_ready.
REQ-022 Push to a full FIFO without a same-cycle pop SHALL drop the new byte, set overrun, and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle on a full FIFO SHALL both succeed, with no overrun.
REQ-024 Push and pop in the same cycle on a one-entry FIFO SHALL leave rx_valid high with the new byte at the head.
REQ-025 err_clr SHALL clear the sticky flags on the next edge; a same-cycle set event SHALL take priority over the clear.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide with wrap-around; full/empty SHALL be decided by MSB comparison.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously reset to: FSM IDLE, counters 0, FIFO empty, rx_valid 0, rx_data 0x00, frame_err/overrun/par_err 0, busy 0.
REQ-028 Synchronizer flops SHALL reset to 1 so that idle line is not seen as a start bit.
REQ-029 Reset asserted mid-byte SHALL abort the frame with no push; after release, the next falling edge SHALL start a fresh frame.

Configuration
REQ-030 With macro UART_TERM_RX_PARITY_EN defined: after data bit 7, PARITY state SHALL sample one bit at BAUD_DIV spacing; if the even-parity check fails, par_err SHALL be set and the byte discarded; STOP follows regardless.
REQ-031 Without UART_TERM_RX_PARITY_EN: no PARITY state; DATA goes directly to STOP; par_err SHALL be tied 0.

Verification
REQ-032 Reset, BAUD_DIV=234, rx_ready=1, send 0x41 8N1 at 234 clk/bit -> one rx_valid pulse with rx_data=0x41, no flags.
REQ-033 rx_ready=0, send back-to-back 0x41,0x42,0x43,0x0D,0x0A -> FIFO holds 41,42,43,0D; overrun=1; then raise rx_ready -> bytes pop in order, with 0x0A absent.
REQ-034 Send 0x55 with stop bit driven 0 -> no push, frame_err=1; pulse err_clr -> frame_err=0.
REQ-035 Drive rxd low for 50 clk, then high -> FSM returns to IDLE, no push, no flags, busy low afterwards.
REQ-036 Assert rst_n during data bit 3 of 0xA5, release, then send 0x3C -> only 0x3C received.
REQ-037 With UART_TERM_RX_PARITY_EN, send 0x07 with parity bit 0 -> par_err=1, no push; send 0x07 with parity bit 1 -> 0x07 received.

Source files
------------

// File: rtl/uart_term_rx.sv
// Terminal-side UART receiver (8 data bits, 1 stop bit) with a small receive FIFO and sticky error flags.
// Optional even-parity bit check is compiled in with macro UART_TERM_RX_PARITY_EN.
module uart_term_rx #(
  parameter int BAUD_DIV   = 234,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       par_err,
  input  logic       err_clr,
  output logic       busy,
  output logic [2:0] dbg_state
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] FULL_M1 = 12'(BAUD_DIV - 1);

`ifdef UART_TERM_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  sync_q;
  logic        rxd_s;
  logic        push, frame_set, ovr_set;
  logic        frame_err_q, overrun_q;

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, pop, wr;

  // Synchronizer presets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end
  assign rxd_s = sync_q[1];

`ifdef UART_TERM_RX_PARITY_EN
  logic par_bad_q, par_bad_d, par_set, par_err_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_TERM_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = HALF_M1;
`ifdef UART_TERM_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL_M1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = rxd_s;
          cnt_d          = FULL_M1;
          if (idx_q == 3'd7) begin
`ifdef UART_TERM_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
`ifdef UART_TERM_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          // Even parity: data bits plus parity bit must hold an even count of ones.
          par_bad_d = ^{shreg_q, rxd_s};
          par_set   = ^{shreg_q, rxd_s};
          state_d   = STOP;
          cnt_d     = FULL_M1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rxd_s) begin
`ifdef UART_TERM_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // FIFO: extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= shreg_q;
        wptr_q                <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Set events win over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~err_clr);
      overrun_q   <= ovr_set | (overrun_q & ~err_clr);
    end
  end

`ifdef UART_TERM_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_set | (par_err_q & ~err_clr);
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign rx_data   = mem_q[rptr_q[AW-1:0]];
  assign rx_valid  = !empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
endmodule
